// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter sequence checker.
package counter_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      StIdle,
      StAcquire,
      StLocked
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/counter_sequence_checker.sv
// Tracks a free-running counter's output stream and flags any step that is not exactly +1.
module counter_sequence_checker
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned ERR_CNT_W = 8,
   parameter int unsigned LOCK_CNT  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 dut_reset,
   input  logic                 clear,
   input  logic [WIDTH-1:0]     q,
   output logic                 locked,
   output logic [WIDTH-1:0]     expected,
   output logic                 err_pulse,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 wrap_pulse
);

   localparam int unsigned RUN_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             armed_q, armed_d;
   logic             err, wrap;
   logic             locked_q, err_pulse_q, wrap_pulse_q, sticky_q;
   logic [WIDTH-1:0] q_inc;
   logic             entry_check;

   assign q_inc = q + WIDTH'(1);

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      run_d       = run_q;
      armed_d     = armed_q;
      err         = 1'b0;
      wrap        = 1'b0;
      entry_check = 1'b0;

      if (dut_reset) begin
         state_d     = StIdle;
         exp_d       = '0;
         run_d       = '0;
         // armed carries "was locked at entry" through the episode until one error fires
         entry_check = (state_q == StLocked) || armed_q;
         if (entry_check && (q != '0)) begin
            err     = 1'b1;
            armed_d = 1'b0;
         end else begin
            armed_d = entry_check;
         end
      end else begin
         armed_d = 1'b0;
         if (en) begin
            case (state_q)
               StIdle: begin
                  state_d = StAcquire;
                  exp_d   = q_inc;
                  run_d   = '0;
               end
               StAcquire: begin
                  exp_d = q_inc;
                  if (q == exp_q) begin
                     if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                        state_d = StLocked;
                        run_d   = '0;
                     end else begin
                        run_d = run_q + RUN_W'(1);
                     end
                  end else begin
                     run_d = '0;
                  end
               end
               StLocked: begin
                  exp_d = q_inc;
                  if (q == exp_q) begin
                     wrap = (q == '0);
                  end else begin
                     err     = 1'b1;
                     state_d = StAcquire;
                     run_d   = '0;
                  end
               end
               default: begin
                  state_d = StIdle;
                  exp_d   = '0;
                  run_d   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         exp_q        <= '0;
         run_q        <= '0;
         armed_q      <= 1'b0;
         locked_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         wrap_pulse_q <= 1'b0;
         sticky_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         run_q        <= run_d;
         armed_q      <= armed_d;
         locked_q     <= (state_d == StLocked);
         err_pulse_q  <= err;
         wrap_pulse_q <= wrap;
         if (clear) begin
            sticky_q <= 1'b0;
         end else if (err) begin
            sticky_q <= 1'b1;
         end
      end
   end

   sat_counter #(
      .W (ERR_CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err),
      .clr   (clear),
      .count (err_count)
   );

   assign locked     = locked_q;
   assign expected   = exp_q;
   assign err_pulse  = err_pulse_q;
   assign wrap_pulse = wrap_pulse_q;
   assign err_sticky = sticky_q;

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Directed bench for counter_sequence_checker with hand-computed expectations.
module tb_counter_sequence_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       dut_reset;
   logic       clear;
   logic [3:0] q;
   logic       locked;
   logic [3:0] expected;
   logic       err_pulse;
   logic       err_sticky;
   logic [7:0] err_count;
   logic       wrap_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   counter_sequence_checker #(
      .WIDTH     (4),
      .ERR_CNT_W (8),
      .LOCK_CNT  (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .dut_reset  (dut_reset),
      .clear      (clear),
      .q          (q),
      .locked     (locked),
      .expected   (expected),
      .err_pulse  (err_pulse),
      .err_sticky (err_sticky),
      .err_count  (err_count),
      .wrap_pulse (wrap_pulse)
   );

   task automatic check_eq(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   // Apply one sample, take the edge, settle 1 time unit past it.
   task automatic step(input logic e, input logic [3:0] v, input logic dr, input logic clr);
      en        = e;
      q         = v;
      dut_reset = dr;
      clear     = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [3:0] v);
      step(1'b1, v, 1'b0, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_locked"}, int'(locked), 0);
      check_eq({tag, "_expected"}, int'(expected), 0);
      check_eq({tag, "_err_pulse"}, int'(err_pulse), 0);
      check_eq({tag, "_err_sticky"}, int'(err_sticky), 0);
      check_eq({tag, "_err_count"}, int'(err_count), 0);
      check_eq({tag, "_wrap_pulse"}, int'(wrap_pulse), 0);
   endtask

   initial begin
      logic [3:0] e;
      reset = 1'b1; en = 1'b0; dut_reset = 1'b0; clear = 1'b0; q = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;

      // Acquire and lock on 0,1,2,3
      sample(4'd0);
      check_eq("acq_q0_locked", int'(locked), 0);
      check_eq("acq_q0_expected", int'(expected), 1);
      sample(4'd1);
      check_eq("acq_q1_locked", int'(locked), 0);
      sample(4'd2);
      check_eq("lock_at_q2", int'(locked), 1);
      sample(4'd3);
      check_eq("exp_after_q3", int'(expected), 4);
      check_eq("no_err_lock", int'(err_count), 0);

      // Wrap 15 -> 0
      for (int i = 4; i <= 15; i++) sample(4'(i));
      check_eq("no_wrap_at_15", int'(wrap_pulse), 0);
      sample(4'd0);
      check_eq("wrap_pulse", int'(wrap_pulse), 1);
      check_eq("wrap_no_err", int'(err_pulse), 0);
      sample(4'd1);
      check_eq("wrap_one_cycle", int'(wrap_pulse), 0);
      check_eq("wrap_cnt0", int'(err_count), 0);

      // Skip 6 -> 8
      for (int i = 2; i <= 6; i++) sample(4'(i));
      sample(4'd8);
      check_eq("skip_err_pulse", int'(err_pulse), 1);
      check_eq("skip_err_count", int'(err_count), 1);
      check_eq("skip_sticky", int'(err_sticky), 1);
      check_eq("skip_unlocked", int'(locked), 0);
      check_eq("skip_rebase", int'(expected), 9);
      sample(4'd9);
      check_eq("skip_pulse_drop", int'(err_pulse), 0);
      check_eq("skip_still_acq", int'(locked), 0);
      sample(4'd10);
      check_eq("relock_q10", int'(locked), 1);

      // Repeated value 11,11
      sample(4'd11);
      sample(4'd11);
      check_eq("repeat_err_pulse", int'(err_pulse), 1);
      check_eq("repeat_err_count", int'(err_count), 2);
      // Mismatch while acquiring is silent
      sample(4'd5);
      check_eq("acq_silent_pulse", int'(err_pulse), 0);
      check_eq("acq_silent_count", int'(err_count), 2);
      check_eq("acq_rebase", int'(expected), 6);
      sample(4'd6);
      sample(4'd7);
      check_eq("relock_q7", int'(locked), 1);

      // en=0 holds everything
      step(1'b0, 4'd3, 1'b0, 1'b0);
      step(1'b0, 4'd9, 1'b0, 1'b0);
      check_eq("hold_err_pulse", int'(err_pulse), 0);
      step(1'b0, 4'd0, 1'b0, 1'b0);
      check_eq("hold_locked", int'(locked), 1);
      check_eq("hold_expected", int'(expected), 8);
      check_eq("hold_wrap", int'(wrap_pulse), 0);
      check_eq("hold_count", int'(err_count), 2);

      // dut_reset with q=0: no error
      step(1'b1, 4'd0, 1'b1, 1'b0);
      check_eq("dr0_locked", int'(locked), 0);
      check_eq("dr0_expected", int'(expected), 0);
      check_eq("dr0_err_pulse", int'(err_pulse), 0);
      step(1'b1, 4'd0, 1'b1, 1'b0);
      check_eq("dr0_count", int'(err_count), 2);

      // Relock, then dut_reset with q=9: exactly one error
      sample(4'd0); sample(4'd1); sample(4'd2);
      check_eq("relock_after_dr", int'(locked), 1);
      step(1'b0, 4'd9, 1'b1, 1'b0);
      check_eq("dr9_err_pulse", int'(err_pulse), 1);
      check_eq("dr9_count", int'(err_count), 3);
      step(1'b0, 4'd9, 1'b1, 1'b0);
      check_eq("dr9_single_pulse", int'(err_pulse), 0);
      check_eq("dr9_single_count", int'(err_count), 3);

      // Saturation: each round is one locked error followed by a two-sample relock
      sample(4'd0); sample(4'd1); sample(4'd2);
      e = 4'd3;
      for (int i = 0; i < 300; i++) begin
         sample(e + 4'd5);
         sample(e + 4'd6);
         sample(e + 4'd7);
         e = e + 4'd8;
      end
      check_eq("sat_count", int'(err_count), 255);
      check_eq("sat_sticky", int'(err_sticky), 1);
      check_eq("sat_locked", int'(locked), 1);

      // Clear on a good sample
      step(1'b1, e, 1'b0, 1'b1);
      check_eq("clear_count", int'(err_count), 0);
      check_eq("clear_sticky", int'(err_sticky), 0);
      // Clear coinciding with an error: counter cleared, pulse still fires
      step(1'b1, e + 4'd4, 1'b0, 1'b1);
      check_eq("clear_err_pulse", int'(err_pulse), 1);
      check_eq("clear_err_count", int'(err_count), 0);

      // Async reset while a pulse is high
      sample(e + 4'd5); sample(e + 4'd6);
      sample(e + 4'd2);
      check_eq("pre_areset_pulse", int'(err_pulse), 1);
      #2 reset = 1'b1;
      #1;
      check_all_zero("areset");
      @(negedge clk);
      reset = 1'b0;
      sample(4'd4);
      check_eq("post_areset_locked", int'(locked), 0);
      check_eq("post_areset_expected", int'(expected), 5);
      check_eq("post_areset_err", int'(err_pulse), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_sequence_checker.md
# counter_sequence_checker

Synchronous checker that sits on the output bus of the team's 4-bit ripple counter and verifies that the counter advances by exactly one per sample, including the wrap from 15 to 0. It locks onto the sequence, flags every skipped or repeated value, counts the errors and reports wraps. It runs alongside the counter in simulation and on-chip self-test, as the reader of the counter's output stream.

## Interface
- WIDTH, 4, width of the observed counter value
- ERR_CNT_W, 8, width of the saturating error counter
- LOCK_CNT, 2, consecutive correct increments required to enter LOCKED (min 1)

- clk  input  1  sampling clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset of the checker
- en  input  1  sample enable; q is examined only in cycles with en=1
- dut_reset  input  1  observed counter is held in reset; q must read 0
- clear  input  1  synchronous clear of err_count and err_sticky
- q  input  WIDTH  observed counter value
- locked  output  1  checker is tracking the sequence
- expected  output  WIDTH  value the next enabled sample must equal
- err_pulse  output  1  one-cycle pulse per detected sequence error
- err_sticky  output  1  set by any error; cleared by reset or clear
- err_count  output  ERR_CNT_W  saturating count of errors
- wrap_pulse  output  1  one-cycle pulse when a correct 2^WIDTH-1 -> 0 step is seen while locked

## Operation
- States: IDLE, ACQUIRE, LOCKED.
- IDLE: leaves on the first enabled sample with dut_reset=0. Goes to ACQUIRE with expected=q+1 and good-run count=0.
- ACQUIRE, enabled sample:
  - q==expected: good-run count increments and expected advances. When the count reaches LOCK_CNT, go to LOCKED.
  - q!=expected: rebase with expected=q+1 and count=0. No error is raised.
- LOCKED, enabled sample:
  - q==expected: expected advances.
  - q!=expected: err_pulse fires, err_sticky is set, err_count increments and saturates at all-ones. Go to ACQUIRE, rebased on q.
- dut_reset=1 (any state, en ignored): go to IDLE, expected=0, no error. A q value other than 0 during dut_reset raises an error only if the state was LOCKED at entry. This is a single error per dut_reset episode.
- Arithmetic: expected=(q+1) mod 2^WIDTH; wrap from all-ones to 0 is legal.
- en=0: state, expected and the good-run count hold. Pulses stay low.
- clear: err_count and err_sticky go to 0 at the next edge. If an error is detected in the same cycle, clear wins for the counter, and err_pulse still fires.

## Timing
- All outputs are registered. Reset values: locked=0, expected=0, err_pulse=0, err_sticky=0, err_count=0, wrap_pulse=0, state=IDLE.
- Latency: a sample taken at edge N produces err_pulse and wrap_pulse high for exactly the cycle after edge N. locked and expected update at edge N.
- Pulses are never held for more than one cycle, even with back-to-back bad samples. Each bad sample in LOCKED yields one pulse. After an error the checker is in ACQUIRE, so subsequent mismatches are silent until it relocks.
- An asynchronous reset asserted mid-sequence forces all outputs to their reset values immediately. The checker resumes from IDLE after reset is deasserted.
- q is treated as synchronous to clk. The counter output is synchronized upstream when needed.

## Structure
- Shared package (counter_pkg): the state enum for IDLE/ACQUIRE/LOCKED and the default WIDTH constant.
- One sub-module, sat_counter, holds the saturating error counter (increment, synchronous clear, saturate).
- Everything else is a single FSM plus datapath in counter_sequence_checker.

## Test plan
- Reset, then en=1 with q=0,1,2,3 -> locked rises at the edge sampling q=2 (LOCK_CNT=2). expected=4 after q=3, err_count=0.
- Locked stream …14,15,0,1 -> wrap_pulse high for one cycle after the q=0 sample, and no error.
- Locked stream 5,6,8,9,10 -> one err_pulse after q=8, err_count=1, err_sticky=1. locked drops at q=8 and rises again at the edge sampling q=10.
- Locked stream with repeated value 7,7 -> one error. en=0 for 3 cycles with q changing -> no state change and no pulses.
- dut_reset=1 while locked with q=0 -> IDLE, no error. Repeat with q=9 during dut_reset -> one error.
- Force 300 errors with ERR_CNT_W=8 -> err_count stops at 255. clear=1 -> err_count=0 and err_sticky=0 next cycle. Assert reset mid-stream -> all outputs return to 0 immediately.
